// File: rtl/fifo_burst_drain_pkg.sv
// Shared types and default sizing for the burst-drain block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_drain_pkg;

  // Drain controller states: waiting for a burst trigger, or issuing reads.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DATA_DEPTH = 512;
  localparam int DEF_BURST_LEN  = 16;
  localparam int DEF_TIMEOUT    = 64;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_burst_drain_if.sv
// Bundle of upstream-FIFO read port and downstream stream signals.
// Latency: n/a (wiring only).
// Backpressure: m_ready from the consumer, fifo_empty from the producer.
interface fifo_burst_drain_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 512
);
  localparam int CW = $clog2(DATA_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] fifo_r_data;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_fcounter;
  logic                  fifo_r_enable;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_sop;
  logic                  m_eop;
  logic                  busy;

  // Drain block side.
  modport master (
    input  fifo_r_data, fifo_empty, fifo_fcounter, m_ready,
    output fifo_r_enable, m_data, m_valid, m_sop, m_eop, busy
  );

  // Environment side: upstream FIFO plus downstream consumer.
  modport slave (
    output fifo_r_data, fifo_empty, fifo_fcounter, m_ready,
    input  fifo_r_enable, m_data, m_valid, m_sop, m_eop, busy
  );
endinterface

// File: rtl/drain_skid_buf.sv
// Two-entry FIFO-ordered output buffer carrying data plus sop/eop tags.
// Latency: one cycle from write to head visible on the output.
// Backpressure: head held stable while valid and not ready; caller must not overfill.
module drain_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_vld,
  input  logic [DATA_WIDTH-1:0] i_wr_dat,
  input  logic                  i_wr_sop,
  input  logic                  i_wr_eop,
  input  logic                  i_rd_rdy,
  output logic                  o_rd_vld,
  output logic [DATA_WIDTH-1:0] o_rd_dat,
  output logic                  o_rd_sop,
  output logic                  o_rd_eop,
  output logic [1:0]            o_count
);
  // Entry layout: {sop, eop, data}.
  localparam int EW = DATA_WIDTH + 2;

  logic [EW-1:0] r_mem [2];
  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_cnt;
  logic          w_pop;
  logic          w_push;
  logic [EW-1:0] w_head;

  assign w_head   = r_mem[r_rp];
  assign o_rd_vld = reset && (r_cnt != 2'd0);
  assign w_pop    = o_rd_vld && i_rd_rdy;
  // A write into a full buffer is only legal when the head leaves the same cycle.
  assign w_push   = i_wr_vld && ((r_cnt != 2'd2) || w_pop);
  assign o_count  = r_cnt;

  // Outputs forced to zero whenever nothing is buffered.
  assign o_rd_dat = o_rd_vld ? w_head[DATA_WIDTH-1:0] : '0;
  assign o_rd_eop = o_rd_vld && w_head[DATA_WIDTH];
  assign o_rd_sop = o_rd_vld && w_head[DATA_WIDTH+1];

  // Storage, pointers and occupancy; simultaneous push and pop keeps count unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {i_wr_sop, i_wr_eop, i_wr_dat};
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/fifo_burst_drain.sv
// Drains an upstream FIFO in bursts (full-length or on idle timeout) into a tagged stream.
// Latency: read data appears on m_data two cycles after fifo_r_enable when unstalled.
// Backpressure: reads throttled so buffered plus in-flight words never exceed two.
module fifo_burst_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  fifo_burst_drain_if.master bus
);
  localparam int CW = occ_width(DATA_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        r_state;
  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_remaining;
  logic          r_first;
  logic          r_inflight;
  logic          r_if_sop;
  logic          r_if_eop;

  logic          w_rd_en;
  logic          w_m_vld;
  logic          w_pop;
  logic [1:0]    w_occ;
  logic [2:0]    w_load;
  logic          w_full_burst;
  logic          w_timed_out;

  assign w_pop        = w_m_vld && bus.m_ready;
  assign w_load       = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_full_burst = (bus.fifo_fcounter >= CW'(BURST_LEN));
  assign w_timed_out  = (r_timer == TW'(TIMEOUT)) && !bus.fifo_empty;

  // The pop term lets a read issue into a slot that is being vacated this cycle.
  assign w_rd_en = reset && (r_state == BURST) && (r_remaining != '0) &&
                   !bus.fifo_empty && (w_load < 3'd2);

  assign bus.fifo_r_enable = w_rd_en;
  assign bus.m_valid       = w_m_vld;
  assign bus.busy          = reset && ((r_state == BURST) || r_inflight || (w_occ != 2'd0));

  // Burst trigger, idle timer and remaining-read count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_full_burst) begin
            r_state     <= BURST;
            r_remaining <= CW'(BURST_LEN);
            r_timer     <= '0;
            r_first     <= 1'b1;
          end else if (w_timed_out) begin
            r_state     <= BURST;
            r_remaining <= bus.fifo_fcounter;
            r_timer     <= '0;
            r_first     <= 1'b1;
          end else if (bus.fifo_empty) begin
            r_timer <= '0;
          end else if (r_timer != TW'(TIMEOUT)) begin
            r_timer <= r_timer + TW'(1);
          end
        end
        BURST: begin
          r_timer <= '0;
          if (w_rd_en) begin
            r_remaining <= r_remaining - CW'(1);
            r_first     <= 1'b0;
            if (r_remaining == CW'(1)) begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Track the read in flight and its burst-position tags until data returns.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_inflight <= 1'b0;
      r_if_sop   <= 1'b0;
      r_if_eop   <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      r_if_sop   <= w_rd_en && r_first;
      r_if_eop   <= w_rd_en && (r_remaining == CW'(1));
    end
  end

  drain_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_wr_vld (r_inflight),
    .i_wr_dat (bus.fifo_r_data),
    .i_wr_sop (r_if_sop),
    .i_wr_eop (r_if_eop),
    .i_rd_rdy (bus.m_ready),
    .o_rd_vld (w_m_vld),
    .o_rd_dat (bus.m_data),
    .o_rd_sop (bus.m_sop),
    .o_rd_eop (bus.m_eop),
    .o_count  (w_occ)
  );

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Directed bench: upstream FIFO model, stream monitor, vector table plus corner sequences.
// Latency: n/a.
// Backpressure: m_ready held high, toggled, or held low per test.
module tb_fifo_burst_drain;
  localparam int DW    = 8;
  localparam int DEPTH = 512;
  localparam int BL    = 16;
  localparam int TO    = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  fifo_burst_drain_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) bus ();

  fifo_burst_drain #(
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DEPTH),
    .BURST_LEN  (BL),
    .TIMEOUT    (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Upstream synchronous FIFO model with occupancy counter.
  logic [DW-1:0] mem [DEPTH];
  int            wp, rp;
  logic [CW-1:0] cnt;
  logic          wr_en;
  logic [DW-1:0] wr_dat;
  logic          fifo_clr;

  always @(posedge clk) begin
    if (fifo_clr) begin
      wp <= 0;
      rp <= 0;
      cnt <= '0;
      bus.fifo_r_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_dat;
        wp <= (wp + 1) % DEPTH;
      end
      if (bus.fifo_r_enable) begin
        bus.fifo_r_data <= mem[rp];
        rp <= (rp + 1) % DEPTH;
      end
      cnt <= cnt + CW'(wr_en) - CW'(bus.fifo_r_enable);
    end
  end
  assign bus.fifo_empty    = (cnt == '0);
  assign bus.fifo_fcounter = cnt;

  // Stream monitor, sampled on the falling edge.
  logic          mon_clr;
  int            beats, rd_cnt, gap, first_rd, last_rd, cyc, max_out, bad_rd, stall_bad;
  bit            rd_seen, p_stall;
  logic [DW-1:0] p_dat;
  logic          p_sop, p_eop;
  logic [DW-1:0] b_dat [64];
  logic          b_sop [64];
  logic          b_eop [64];

  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      beats = 0; rd_cnt = 0; gap = 0; first_rd = 0; last_rd = 0;
      max_out = 0; bad_rd = 0; stall_bad = 0; rd_seen = 0; p_stall = 0;
    end else if (reset) begin
      if (bus.fifo_r_enable) begin
        if (!rd_seen) first_rd = cyc;
        rd_seen = 1;
        last_rd = cyc;
        rd_cnt++;
        if (bus.fifo_empty) bad_rd++;
      end else if (!rd_seen && !bus.fifo_empty) begin
        gap++;
      end
      if (p_stall && (!bus.m_valid || bus.m_data !== p_dat ||
                      bus.m_sop !== p_sop || bus.m_eop !== p_eop)) stall_bad++;
      if (bus.m_valid && bus.m_ready) begin
        if (beats < 64) begin
          b_dat[beats] = bus.m_data;
          b_sop[beats] = bus.m_sop;
          b_eop[beats] = bus.m_eop;
        end
        beats++;
      end
      if (rd_cnt - beats > max_out) max_out = rd_cnt - beats;
      p_stall = bus.m_valid && !bus.m_ready;
      p_dat = bus.m_data;
      p_sop = bus.m_sop;
      p_eop = bus.m_eop;
    end else begin
      if (bus.fifo_r_enable) bad_rd++;
      p_stall = 0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic step(input int tog);
    @(posedge clk);
    #1;
    if (tog != 0) bus.m_ready = ~bus.m_ready;
  endtask

  task automatic chk_outputs_zero(input string nm);
    @(negedge clk);
    chk({nm, " r_enable"}, int'(bus.fifo_r_enable), 0);
    chk({nm, " m_valid"},  int'(bus.m_valid), 0);
    chk({nm, " m_sop"},    int'(bus.m_sop), 0);
    chk({nm, " m_eop"},    int'(bus.m_eop), 0);
    chk({nm, " busy"},     int'(bus.busy), 0);
    chk({nm, " m_data"},   int'(bus.m_data), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0; fifo_clr = 1'b1; mon_clr = 1'b1; wr_en = 1'b0; bus.m_ready = 1'b0;
    step(0);
    step(0);
    reset = 1'b1; fifo_clr = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic write_words(input int n, input int base, input int tog);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      wr_dat = DW'(base + i);
      step(tog);
    end
    wr_en = 1'b0;
  endtask

  // Beat i carries base+i; sop at start of each burst, eop at end.
  task automatic chk_beats(input string nm, input int n, input int base, input int len0, input int len1);
    for (int i = 0; i < n && i < beats; i++) begin
      chk($sformatf("%s beat%0d data", nm, i), int'(b_dat[i]), (base + i) & 8'hFF);
      chk($sformatf("%s beat%0d sop", nm, i), int'(b_sop[i]), int'(i == 0 || i == len0));
      chk($sformatf("%s beat%0d eop", nm, i), int'(b_eop[i]),
          int'(i == len0 - 1 || (len1 != 0 && i == len0 + len1 - 1)));
    end
  endtask

  typedef struct {
    int nwords;
    int toggle;
    int exp_gap;
    int exp_span;
    int len0;
    int len1;
    int base;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    string nm;
    nm = $sformatf("v%0dw_t%0d", v.nwords, v.toggle);
    do_reset();
    bus.m_ready = 1'b1;
    write_words(v.nwords, v.base, v.toggle);
    for (int c = 0; c < 600 && beats < v.nwords; c++) step(v.toggle);
    repeat (4) step(v.toggle);
    @(negedge clk);
    chk({nm, " beats"}, beats, v.nwords);
    chk({nm, " idle_gap"}, gap, v.exp_gap);
    if (v.exp_span != 0) chk({nm, " read_span"}, last_rd - first_rd + 1, v.exp_span);
    chk({nm, " reads"}, rd_cnt, v.nwords);
    chk_beats(nm, v.nwords, v.base, v.len0, v.len1);
    chk({nm, " max_outstanding_le2"}, int'(max_out <= 2), 1);
    chk({nm, " read_while_empty"}, bad_rd, 0);
    chk({nm, " stall_unstable"}, stall_bad, 0);
    chk({nm, " busy_end"}, int'(bus.busy), 0);
  endtask

  int rd_before;
  int rem;

  initial begin
    // nwords, toggle, idle gap, read span, burst lengths, first word
    vecs[0] = '{16, 0, 16,     16, 16, 0,  'h00};
    vecs[1] = '{3,  0, TO + 1, 3,  3,  0,  'h40};
    vecs[2] = '{1,  0, TO + 1, 1,  1,  0,  'h80};
    vecs[3] = '{32, 1, 16,     0,  16, 16, 'h20};
    vecs[4] = '{20, 1, 16,     0,  16, 4,  'hA0};
    vecs[5] = '{17, 0, 16,     0,  16, 1,  'hC0};

    // Outputs during reset and after release with an empty upstream FIFO.
    reset = 1'b0; fifo_clr = 1'b1; mon_clr = 1'b1; wr_en = 1'b0; wr_dat = '0;
    bus.m_ready = 1'b1;
    step(0);
    chk_outputs_zero("in_reset");
    step(0);
    reset = 1'b1; fifo_clr = 1'b0; mon_clr = 1'b0;
    step(0);
    chk_outputs_zero("after_reset");

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Consumer never ready: only two reads may be issued.
    do_reset();
    bus.m_ready = 1'b0;
    write_words(16, 'h50, 0);
    repeat (40) step(0);
    @(negedge clk);
    chk("stall reads", rd_cnt, 2);
    chk("stall fcounter", int'(bus.fifo_fcounter), 14);
    chk("stall m_valid", int'(bus.m_valid), 1);
    chk("stall m_data", int'(bus.m_data), 'h50);
    chk("stall m_sop", int'(bus.m_sop), 1);
    chk("stall m_eop", int'(bus.m_eop), 0);
    chk("stall busy", int'(bus.busy), 1);
    step(0);
    bus.m_ready = 1'b1;
    for (int c = 0; c < 200 && beats < 16; c++) step(0);
    repeat (4) step(0);
    @(negedge clk);
    chk("stall beats", beats, 16);
    chk_beats("stall", 16, 'h50, 16, 0);
    chk("stall unstable", stall_bad, 0);
    chk("stall max_outstanding_le2", int'(max_out <= 2), 1);

    // Reset on the eighth beat of a full burst, then a fresh timeout burst.
    do_reset();
    bus.m_ready = 1'b1;
    write_words(16, 'h60, 0);
    for (int c = 0; c < 200 && beats < 8; c++) step(0);
    chk("rst beats_before", beats, 8);
    rd_before = rd_cnt;
    reset = 1'b0;
    mon_clr = 1'b1;
    chk_outputs_zero("mid_reset");
    step(0);
    reset = 1'b1;
    mon_clr = 1'b0;
    rem = 16 - rd_before;
    chk("rst fcounter_kept", int'(bus.fifo_fcounter), rem);
    for (int c = 0; c < 300 && beats < rem; c++) step(0);
    repeat (4) step(0);
    @(negedge clk);
    chk("rst beats", beats, rem);
    chk("rst idle_gap", gap, TO + 1);
    chk_beats("rst", rem, 'h60 + rd_before, rem, 0);
    chk("rst busy_end", int'(bus.busy), 0);
    chk("rst read_while_empty", bad_rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
